dot_line_fetcher: RTL and testbench

- Sequences the shared 8x8 dot-glyph ROM (32 x 8, address = {code[1:0], row[2:0]}) for the VGA pan/bias indicator strip.
- On each scanline start it walks N_CELLS cell codes and fetches the current glyph row for each cell into a back line buffer.
- At completion it swaps the back buffer to the front, so the pixel renderer always reads a stable, complete line.
- Sits between the sampler's indicator-state writer, the dot ROM, and the VGA colour mapper.

---
 rtl/dot_pkg.sv | 34 +++
 rtl/dot_line_buf.sv | 60 ++++++
 rtl/dot_line_fetcher.sv | 184 ++++++++++++++++++
 tb/tb_dot_line_fetcher.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared types and constants for the dot-glyph line fetcher.
//   glyph_code_t  : 2-bit cell code selecting one of four glyphs
//   fetch_state_t : fetcher FSM states (DRAIN exists only when the
//                   ROM output is registered, macro DOT_ROM_REG_EN)
//   GLYPH_ROWS / GLYPH_W / DOT_ROM_AW : glyph geometry and ROM address width
package dot_pkg;

    localparam int GLYPH_ROWS = 8;
    localparam int GLYPH_W    = 8;
    localparam int DOT_ROM_AW = 5;

    typedef enum logic [1:0] {
        BLANK      = 2'd0,
        LEFT_BIAS  = 2'd1,
        RIGHT_BIAS = 2'd2,
        RESV       = 2'd3
    } glyph_code_t;

`ifdef DOT_ROM_REG_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SWAP  = 2'd3
    } fetch_state_t;
`endif

endpackage

// File: rtl/dot_line_buf.sv
// Double-buffered glyph line store.
// One buffer is the front (read by the renderer), the other is the back
// (filled by the fetcher). A swap pulse exchanges the two roles.
// Ports:
//   Clk, Reset_n : clock, async active-low reset (clears both buffers, front = 0)
//   wr_en        : write wr_data into back[wr_idx]
//   wr_idx       : back-buffer cell index
//   wr_data      : glyph row bits
//   swap         : toggle front/back selection at the clock edge
//   rd_idx       : front-buffer cell index
//   rd_data      : front[rd_idx], combinational
module dot_line_buf
    import dot_pkg::*;
#(
    parameter int CELL_AW = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               wr_en,
    input  logic [CELL_AW-1:0] wr_idx,
    input  logic [GLYPH_W-1:0] wr_data,
    input  logic               swap,
    input  logic [CELL_AW-1:0] rd_idx,
    output logic [GLYPH_W-1:0] rd_data
);

    // Storage covers the full index space so any index is in range;
    // entries at or above the cell count are never written and read as zero.
    localparam int DEPTH = 1 << CELL_AW;

    logic [GLYPH_W-1:0] line0 [DEPTH];
    logic [GLYPH_W-1:0] line1 [DEPTH];
    logic               front_sel;

    // A write and a swap on the same edge both use the old front_sel,
    // so the final cell lands in the buffer that is becoming the front.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                line0[i] <= '0;
                line1[i] <= '0;
            end
            front_sel <= 1'b0;
        end else begin
            if (wr_en) begin
                if (front_sel) begin
                    line0[wr_idx] <= wr_data;
                end else begin
                    line1[wr_idx] <= wr_data;
                end
            end
            if (swap) begin
                front_sel <= ~front_sel;
            end
        end
    end

    assign rd_data = front_sel ? line1[rd_idx] : line0[rd_idx];

endmodule

// File: rtl/dot_line_fetcher.sv
// Scanline glyph fetcher for the pan/bias indicator strip.
// On line_start it walks every cell code, reads the selected glyph row from
// the shared dot ROM into the back line buffer, then swaps buffers so the
// renderer only ever sees complete lines.
// Build option: DOT_ROM_REG_EN -- ROM output registered (1-cycle latency);
// fetches are pipelined and a DRAIN state captures the last cell.
// Ports:
//   Clk, Reset_n           : clock, async active-low reset
//   line_start, glyph_row  : start a line fetch for the given glyph row
//   code_we/waddr/wdata    : cell code file write port
//   rom_addr, rom_data     : dot ROM interface, address {code, row}
//   pix_cell, pix_bits     : renderer read of the front buffer
//   busy, done, overrun    : fetch active, swap pulse, sticky restart flag
//
// state | meaning
// IDLE  | waiting for line_start, rom_addr holds last value
// FETCH | issuing one ROM address per cell, idx 0..N_CELLS-1
// DRAIN | registered ROM only: capture the final cell's data
// SWAP  | back buffer becomes front, done pulse
module dot_line_fetcher
    import dot_pkg::*;
#(
    parameter int N_CELLS = 16,
    parameter int CELL_AW = $clog2(N_CELLS)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  line_start,
    input  logic [2:0]            glyph_row,
    input  logic                  code_we,
    input  logic [CELL_AW-1:0]    code_waddr,
    input  logic [1:0]            code_wdata,
    output logic [DOT_ROM_AW-1:0] rom_addr,
    input  logic [GLYPH_W-1:0]    rom_data,
    input  logic [CELL_AW-1:0]    pix_cell,
    output logic [GLYPH_W-1:0]    pix_bits,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int                 DEPTH    = 1 << CELL_AW;
    localparam logic [CELL_AW-1:0] LAST_IDX = CELL_AW'(N_CELLS - 1);

    fetch_state_t          state_q, state_d;
    logic [CELL_AW-1:0]    idx_q, idx_d;
    logic [2:0]            row_q, row_d;
    logic [DOT_ROM_AW-1:0] addr_q;
    logic [DOT_ROM_AW-1:0] fetch_addr;
    logic                  overrun_q;
    logic                  start_fetch;
    logic                  swap;
    logic                  wr_en;
    logic [CELL_AW-1:0]    wr_idx;
    glyph_code_t           code_q [DEPTH];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                code_q[i] <= BLANK;
            end
        end else if (code_we) begin
            code_q[code_waddr] <= glyph_code_t'(code_wdata);
        end
    end

    assign fetch_addr = {code_q[idx_q], row_q};
    assign rom_addr   = (state_q == FETCH) ? fetch_addr : addr_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            if (state_q == FETCH) begin
                addr_q <= fetch_addr;
            end
            if (line_start && busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        row_d       = row_q;
        start_fetch = 1'b0;
        swap        = 1'b0;
        case (state_q)
            IDLE: begin
                if (line_start) start_fetch = 1'b1;
            end
            FETCH: begin
                if (line_start) begin
                    start_fetch = 1'b1;
                end else if (idx_q == LAST_IDX) begin
`ifdef DOT_ROM_REG_EN
                    state_d = DRAIN;
`else
                    state_d = SWAP;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`ifdef DOT_ROM_REG_EN
            DRAIN: begin
                if (line_start) begin
                    start_fetch = 1'b1;
                end else begin
                    state_d = SWAP;
                end
            end
`endif
            SWAP: begin
                // The swap always completes; a coincident line_start
                // simply queues the next fetch behind it.
                swap = 1'b1;
                if (line_start) begin
                    start_fetch = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start_fetch) begin
            state_d = FETCH;
            idx_d   = '0;
            row_d   = glyph_row;
        end
    end

`ifdef DOT_ROM_REG_EN
    // Data for the address issued in cycle i arrives in cycle i+1, so the
    // write index trails the fetch index by one cycle. A capture still in
    // flight when a fill is aborted lands in the back buffer, which the
    // restarted fill overwrites completely before the next swap.
    logic               cap_valid_q;
    logic [CELL_AW-1:0] cap_idx_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            cap_valid_q <= (state_q == FETCH) && !line_start;
            cap_idx_q   <= idx_q;
        end
    end

    assign wr_en  = cap_valid_q;
    assign wr_idx = cap_idx_q;
    assign busy   = (state_q == FETCH) || (state_q == DRAIN);
`else
    assign wr_en  = (state_q == FETCH) && !line_start;
    assign wr_idx = idx_q;
    assign busy   = (state_q == FETCH);
`endif

    assign done    = swap;
    assign overrun = overrun_q;

    dot_line_buf #(
        .CELL_AW (CELL_AW)
    ) u_line_buf (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (rom_data),
        .swap    (swap),
        .rd_idx  (pix_cell),
        .rd_data (pix_bits)
    );

endmodule

// File: tb/tb_dot_line_fetcher.sv
// Self-checking bench for dot_line_fetcher: glyph ROM model, table-driven
// vectors, hand-written corner sequences and randomized lines checked
// against a line-level reference model.
module tb_dot_line_fetcher;

    localparam int N  = 16;
    localparam int AW = 4;
`ifdef DOT_ROM_REG_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N + 1;
`endif

    logic          Clk        = 1'b0;
    logic          Reset_n    = 1'b0;
    logic          line_start = 1'b0;
    logic [2:0]    glyph_row  = 3'd0;
    logic          code_we    = 1'b0;
    logic [AW-1:0] code_waddr = '0;
    logic [1:0]    code_wdata = 2'd0;
    logic [4:0]    rom_addr;
    logic [7:0]    rom_data;
    logic [AW-1:0] pix_cell   = '0;
    logic [7:0]    pix_bits;
    logic          busy, done, overrun;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] glyph [4][8];
    logic [1:0] model_code  [N];
    logic [7:0] model_front [N];
    logic       model_overrun;

    typedef struct {
        logic [2:0] row;
        logic [1:0] c3;
        logic [1:0] c7;
        logic [7:0] exp3;
        logic [7:0] exp7;
    } vec_t;

    vec_t vecs [5];

    dot_line_fetcher #(.N_CELLS(N)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .line_start (line_start),
        .glyph_row  (glyph_row),
        .code_we    (code_we),
        .code_waddr (code_waddr),
        .code_wdata (code_wdata),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_cell   (pix_cell),
        .pix_bits   (pix_bits),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

`ifdef DOT_ROM_REG_EN
    always @(posedge Clk) rom_data <= glyph[rom_addr[4:3]][rom_addr[2:0]];
`else
    assign rom_data = glyph[rom_addr[4:3]][rom_addr[2:0]];
`endif

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_code(input int c, input logic [1:0] v);
        code_we    = 1'b1;
        code_waddr = AW'(c);
        code_wdata = v;
        tick();
        code_we    = 1'b0;
        model_code[c] = v;
    endtask

    task automatic pulse_start(input logic [2:0] r);
        line_start = 1'b1;
        glyph_row  = r;
        tick();
        line_start = 1'b0;
    endtask

    // Called in the first cycle after the line_start edge; counts cycles
    // up to and including the done cycle.
    task automatic wait_done(input string name);
        int lat;
        lat = 1;
        while (done !== 1'b1 && lat < 4 * N) begin
            tick();
            lat++;
        end
        check(name, lat, LAT);
    endtask

    function automatic logic [7:0] ref_bits(input logic [1:0] code, input logic [2:0] row);
        return glyph[code][row];
    endfunction

    task automatic commit_line(input logic [2:0] r);
        for (int c = 0; c < N; c++) model_front[c] = ref_bits(model_code[c], r);
    endtask

    task automatic read_pix(input int c, output logic [7:0] v);
        pix_cell = AW'(c);
        #1;
        v = pix_bits;
    endtask

    task automatic check_front(input string name);
        logic [7:0] v;
        for (int c = 0; c < N; c++) begin
            read_pix(c, v);
            check($sformatf("%s cell%0d", name, c), v, model_front[c]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        logic [7:0] prev3;
        logic [2:0] r;
        int         lat;

        glyph[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        glyph[1] = '{8'h81, 8'h42, 8'h20, 8'h10, 8'h38, 8'h7C, 8'hFE, 8'h18};
        glyph[2] = '{8'hC3, 8'h24, 8'h04, 8'h08, 8'h1C, 8'h3E, 8'h7F, 8'h99};
        glyph[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int c = 0; c < N; c++) begin
            model_code[c]  = 2'd0;
            model_front[c] = 8'h00;
        end
        model_overrun = 1'b0;

        vecs[0] = '{3'd4, 2'd1, 2'd2, 8'h38, 8'h1C};
        vecs[1] = '{3'd3, 2'd1, 2'd2, 8'h10, 8'h08};
        vecs[2] = '{3'd0, 2'd2, 2'd1, 8'hC3, 8'h81};
        vecs[3] = '{3'd6, 2'd0, 2'd1, 8'h00, 8'hFE};
        vecs[4] = '{3'd7, 2'd3, 2'd2, 8'h00, 8'h99};

        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        tick();
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset overrun", overrun, 1'b0);
        check("reset rom_addr", rom_addr, 5'd0);
        check_front("reset");

        prev3 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            write_code(3, vecs[i].c3);
            write_code(7, vecs[i].c7);
            pulse_start(vecs[i].row);
            check("fetch busy", busy, 1'b1);
            read_pix(3, v);
            check("front held during fetch", v, prev3);
            wait_done("table latency");
            tick();
            commit_line(vecs[i].row);
            read_pix(3, v);
            check("table cell3", v, vecs[i].exp3);
            read_pix(7, v);
            check("table cell7", v, vecs[i].exp7);
            check_front("table");
            prev3 = vecs[i].exp3;
        end

        // RESV everywhere: every fetch address is {3, 4}
        for (int c = 0; c < N; c++) write_code(c, 2'd3);
        pulse_start(3'd4);
        lat = 1;
        while (done !== 1'b1 && lat < 4 * N) begin
            check("resv rom_addr", rom_addr, 5'd28);
            tick();
            lat++;
        end
        check("resv latency", lat, LAT);
        tick();
        check("resv idle rom_addr", rom_addr, 5'd28);
        commit_line(3'd4);
        check_front("resv");

        // Restart while busy
        for (int c = 0; c < N; c++) write_code(c, (c == 3) ? 2'd1 : (c == 7) ? 2'd2 : 2'd0);
        pulse_start(3'd4);
        wait_done("pre-overrun latency");
        tick();
        commit_line(3'd4);
        check("overrun clear", overrun, 1'b0);
        pulse_start(3'd2);
        repeat (4) tick();
        pulse_start(3'd5);
        model_overrun = 1'b1;
        check("overrun set", overrun, 1'b1);
        read_pix(3, v);
        check("overrun front held", v, 8'h38);
        wait_done("overrun latency");
        tick();
        commit_line(3'd5);
        check_front("overrun line");

        // Reset in the middle of a fetch
        pulse_start(3'd1);
        repeat (7) tick();
        Reset_n = 1'b0;
        #1;
        check("midreset busy", busy, 1'b0);
        check("midreset overrun", overrun, 1'b0);
        check("midreset rom_addr", rom_addr, 5'd0);
        read_pix(3, v);
        check("midreset pix", v, 8'h00);
        for (int c = 0; c < N; c++) begin
            model_code[c]  = 2'd0;
            model_front[c] = 8'h00;
        end
        model_overrun = 1'b0;
        #2 Reset_n = 1'b1;
        tick();
        pulse_start(3'd4);
        wait_done("blank latency");
        tick();
        commit_line(3'd4);
        check_front("blank codes");

        // line_start coinciding with the SWAP cycle
        write_code(3, 2'd1);
        write_code(7, 2'd2);
        pulse_start(3'd4);
        wait_done("swap-start first latency");
        pulse_start(3'd6);
        commit_line(3'd4);
        check("swap-start overrun", overrun, 1'b0);
        check("swap-start busy", busy, 1'b1);
        read_pix(3, v);
        check("swap-start front", v, model_front[3]);
        wait_done("swap-start second latency");
        tick();
        commit_line(3'd6);
        check_front("swap-start line");

        // Randomized lines with occasional restarts
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) begin
                write_code($urandom_range(0, N - 1), 2'($urandom_range(0, 3)));
            end
            r = 3'($urandom_range(0, 7));
            pulse_start(r);
            if ($urandom_range(0, 2) == 0) begin
                int k;
                int c;
                k = $urandom_range(0, N - 2);
                repeat (k) tick();
                c = $urandom_range(0, N - 1);
                read_pix(c, v);
                check("rand front held", v, model_front[c]);
                r = 3'($urandom_range(0, 7));
                pulse_start(r);
                model_overrun = 1'b1;
            end
            wait_done("rand latency");
            tick();
            commit_line(r);
            check_front("rand");
            check("rand overrun", overrun, model_overrun);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
